game_state_engine: RTL and testbench

- Parametrised game-logic core that owns the sprite positions for one pacman and NUM_GHOSTS ghosts.
- Applies one-hot move directions on a shared movement tick, with ghosts moving at a divided rate.
- Detects pacman/ghost collisions and runs a lives/death/game-over state machine.
- Sits between the button input decoder / ghost AI blocks and the VGA sprite renderer.

---
 rtl/game_state_engine.sv | 199 +++++++++++++++++++
 tb/tb_game_state_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_engine.sv
// Game-logic core: pacman/ghost positions, movement with clamping, collision
// detection and the lives / death / game-over state machine.
module game_state_engine #(
  parameter int unsigned NUM_GHOSTS  = 4,
  parameter int unsigned X_W         = 11,
  parameter int unsigned Y_W         = 10,
  parameter int unsigned STEP        = 1,
  parameter int unsigned X_MIN       = 0,
  parameter int unsigned X_MAX       = 1279,
  parameter int unsigned Y_MIN       = 0,
  parameter int unsigned Y_MAX       = 1023,
  parameter int unsigned HIT_DIST    = 16,
  parameter int unsigned GHOST_DIV   = 2,
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned DEATH_TICKS = 8,
  parameter int unsigned PAC_RST_X   = 967,
  parameter int unsigned PAC_RST_Y   = 66,
  parameter logic [NUM_GHOSTS*X_W-1:0] GHOST_RST_X = {11'd615, 11'd503, 11'd615, 11'd663},
  parameter logic [NUM_GHOSTS*Y_W-1:0] GHOST_RST_Y = {10'd370, 10'd66, 10'd258, 10'd434}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      move_tick,
  input  logic                      start,
  input  logic                      pause,
  input  logic [3:0]                pacman_move_dir,
  input  logic [NUM_GHOSTS*4-1:0]   ghost_move_dir,
  output logic [X_W-1:0]            pacman_pos_x,
  output logic [Y_W-1:0]            pacman_pos_y,
  output logic [NUM_GHOSTS*X_W-1:0] ghost_pos_x,
  output logic [NUM_GHOSTS*Y_W-1:0] ghost_pos_y,
  output logic [NUM_GHOSTS*4-1:0]   ghost_prev_dir,
  output logic                      pacman_is_dead,
  output logic [2:0]                lives,
  output logic [1:0]                game_state
);

  localparam int unsigned GDIV_W = (GHOST_DIV > 1) ? $clog2(GHOST_DIV) : 1;
  localparam int unsigned DCNT_W = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  state_e                           state_q;
  logic [2:0]                       lives_q;
  logic                             dead_q;
  logic [X_W-1:0]                   pac_x_q, pac_x_d;
  logic [Y_W-1:0]                   pac_y_q, pac_y_d;
  logic [NUM_GHOSTS-1:0][X_W-1:0]   gh_x_q, gh_x_d;
  logic [NUM_GHOSTS-1:0][Y_W-1:0]   gh_y_q, gh_y_d;
  logic [NUM_GHOSTS-1:0][3:0]       gh_prev_q, gh_prev_d;
  logic [GDIV_W-1:0]                gdiv_q;
  logic [DCNT_W-1:0]                dcnt_q;
  logic                             hit_c;

  // Moves are computed one bit wider so the clamp never sees a wrapped value.
  function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x, input logic [3:0] dir);
    logic [X_W:0] xe;
    xe     = {1'b0, x};
    step_x = x;
    if (dir == DIR_RIGHT) begin
      xe     = xe + (X_W+1)'(STEP);
      step_x = (xe > (X_W+1)'(X_MAX)) ? X_W'(X_MAX) : xe[X_W-1:0];
    end else if (dir == DIR_LEFT) begin
      step_x = (xe < (X_W+1)'(X_MIN + STEP)) ? X_W'(X_MIN) : X_W'(xe - (X_W+1)'(STEP));
    end
  endfunction

  function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] y, input logic [3:0] dir);
    logic [Y_W:0] ye;
    ye     = {1'b0, y};
    step_y = y;
    if (dir == DIR_DOWN) begin
      ye     = ye + (Y_W+1)'(STEP);
      step_y = (ye > (Y_W+1)'(Y_MAX)) ? Y_W'(Y_MAX) : ye[Y_W-1:0];
    end else if (dir == DIR_UP) begin
      step_y = (ye < (Y_W+1)'(Y_MIN + STEP)) ? Y_W'(Y_MIN) : Y_W'(ye - (Y_W+1)'(STEP));
    end
  endfunction

  function automatic logic [X_W-1:0] abs_dx(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [Y_W-1:0] abs_dy(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Candidate positions if a move were applied this edge; invalid vectors hold.
  always_comb begin
    pac_x_d = step_x(pac_x_q, pacman_move_dir);
    pac_y_d = step_y(pac_y_q, pacman_move_dir);
    for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
      gh_x_d[i]    = step_x(gh_x_q[i], ghost_move_dir[4*i +: 4]);
      gh_y_d[i]    = step_y(gh_y_q[i], ghost_move_dir[4*i +: 4]);
      gh_prev_d[i] = $onehot(ghost_move_dir[4*i +: 4]) ? ghost_move_dir[4*i +: 4] : gh_prev_q[i];
    end
  end

  always_comb begin
    hit_c = 1'b0;
    for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
      if ((abs_dx(pac_x_q, gh_x_q[i]) < X_W'(HIT_DIST)) &&
          (abs_dy(pac_y_q, gh_y_q[i]) < Y_W'(HIT_DIST))) begin
        hit_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      lives_q   <= 3'd0;
      dead_q    <= 1'b0;
      pac_x_q   <= X_W'(PAC_RST_X);
      pac_y_q   <= Y_W'(PAC_RST_Y);
      gh_x_q    <= GHOST_RST_X;
      gh_y_q    <= GHOST_RST_Y;
      gh_prev_q <= '0;
      gdiv_q    <= '0;
      dcnt_q    <= '0;
    end else begin
      dead_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state_q   <= ST_PLAY;
            lives_q   <= 3'(LIVES_INIT);
            pac_x_q   <= X_W'(PAC_RST_X);
            pac_y_q   <= Y_W'(PAC_RST_Y);
            gh_x_q    <= GHOST_RST_X;
            gh_y_q    <= GHOST_RST_Y;
            gh_prev_q <= '0;
            gdiv_q    <= '0;
          end
        end
        ST_PLAY: begin
          // A collision takes priority over any move on the same edge.
          if (!pause) begin
            if (hit_c) begin
              state_q <= ST_DYING;
              lives_q <= lives_q - 3'd1;
              dcnt_q  <= '0;
              dead_q  <= 1'b1;
            end else if (move_tick) begin
              pac_x_q <= pac_x_d;
              pac_y_q <= pac_y_d;
              if (gdiv_q == GDIV_W'(GHOST_DIV - 1)) begin
                gh_x_q    <= gh_x_d;
                gh_y_q    <= gh_y_d;
                gh_prev_q <= gh_prev_d;
                gdiv_q    <= '0;
              end else begin
                gdiv_q <= gdiv_q + GDIV_W'(1);
              end
            end
          end
        end
        ST_DYING: begin
          if (move_tick) begin
            if (dcnt_q == DCNT_W'(DEATH_TICKS - 1)) begin
              if (lives_q == 3'd0) begin
                state_q <= ST_OVER;
              end else begin
                state_q <= ST_PLAY;
                pac_x_q <= X_W'(PAC_RST_X);
                pac_y_q <= Y_W'(PAC_RST_Y);
                gh_x_q  <= GHOST_RST_X;
                gh_y_q  <= GHOST_RST_Y;
                gdiv_q  <= '0;
              end
            end else begin
              dcnt_q <= dcnt_q + DCNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign pacman_pos_x   = pac_x_q;
  assign pacman_pos_y   = pac_y_q;
  assign ghost_pos_x    = gh_x_q;
  assign ghost_pos_y    = gh_y_q;
  assign ghost_prev_dir = gh_prev_q;
  assign pacman_is_dead = dead_q;
  assign lives          = lives_q;
  assign game_state     = state_q;

endmodule

// File: tb/tb_game_state_engine.sv
// Directed bench for game_state_engine using four instances with different spawn points.
module tb_game_state_engine;

  logic        clk;
  logic        rst;
  logic        move_tick;
  logic        start;
  logic        pause;
  logic [3:0]  pac_dir;
  logic [15:0] gh_dir;

  int checks;
  int errors;

  // d_: default spawns, c_: pacman at (0,0), h_: ghost0 at (991,66), o_: ghost0 overlapping at (975,66)
  logic [1:0]  d_state, c_state, h_state, o_state;
  logic [2:0]  d_lives, c_lives, h_lives, o_lives;
  logic        d_dead, c_dead, h_dead, o_dead;
  logic [10:0] d_px, c_px, h_px, o_px;
  logic [9:0]  d_py, c_py, h_py, o_py;
  logic [43:0] d_gx, c_gx, h_gx, o_gx;
  logic [39:0] d_gy, c_gy, h_gy, o_gy;
  logic [15:0] d_gprev, c_gprev, h_gprev, o_gprev;

  game_state_engine u_def (
    .clk(clk), .rst(rst), .move_tick(move_tick), .start(start), .pause(pause),
    .pacman_move_dir(pac_dir), .ghost_move_dir(gh_dir),
    .pacman_pos_x(d_px), .pacman_pos_y(d_py), .ghost_pos_x(d_gx), .ghost_pos_y(d_gy),
    .ghost_prev_dir(d_gprev), .pacman_is_dead(d_dead), .lives(d_lives), .game_state(d_state)
  );

  game_state_engine #(.PAC_RST_X(0), .PAC_RST_Y(0)) u_clp (
    .clk(clk), .rst(rst), .move_tick(move_tick), .start(start), .pause(pause),
    .pacman_move_dir(pac_dir), .ghost_move_dir(gh_dir),
    .pacman_pos_x(c_px), .pacman_pos_y(c_py), .ghost_pos_x(c_gx), .ghost_pos_y(c_gy),
    .ghost_prev_dir(c_gprev), .pacman_is_dead(c_dead), .lives(c_lives), .game_state(c_state)
  );

  game_state_engine #(
    .GHOST_RST_X({11'd615, 11'd503, 11'd615, 11'd991}),
    .GHOST_RST_Y({10'd370, 10'd66, 10'd258, 10'd66})
  ) u_hit (
    .clk(clk), .rst(rst), .move_tick(move_tick), .start(start), .pause(pause),
    .pacman_move_dir(pac_dir), .ghost_move_dir(gh_dir),
    .pacman_pos_x(h_px), .pacman_pos_y(h_py), .ghost_pos_x(h_gx), .ghost_pos_y(h_gy),
    .ghost_prev_dir(h_gprev), .pacman_is_dead(h_dead), .lives(h_lives), .game_state(h_state)
  );

  game_state_engine #(
    .GHOST_RST_X({11'd615, 11'd503, 11'd615, 11'd975}),
    .GHOST_RST_Y({10'd370, 10'd66, 10'd258, 10'd66})
  ) u_ovl (
    .clk(clk), .rst(rst), .move_tick(move_tick), .start(start), .pause(pause),
    .pacman_move_dir(pac_dir), .ghost_move_dir(gh_dir),
    .pacman_pos_x(o_px), .pacman_pos_y(o_py), .ghost_pos_x(o_gx), .ghost_pos_y(o_gy),
    .ghost_prev_dir(o_gprev), .pacman_is_dead(o_dead), .lives(o_lives), .game_state(o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; move_tick = 1'b0; start = 1'b0; pause = 1'b0; pac_dir = 4'd0; gh_dir = 16'd0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (d_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", d_state); end
    checks++; if (d_lives !== 3'd0) begin errors++; $display("FAIL reset_lives: got %0d expected 0", d_lives); end
    checks++; if (d_dead !== 1'b0) begin errors++; $display("FAIL reset_dead: got %0d expected 0", d_dead); end
    checks++; if (d_gprev !== 16'h0) begin errors++; $display("FAIL reset_gprev: got %0h expected 0", d_gprev); end
    checks++; if (d_px !== 11'd967 || d_py !== 10'd66) begin errors++; $display("FAIL reset_pac: got (%0d,%0d) expected (967,66)", d_px, d_py); end
    checks++; if (d_gx[10:0] !== 11'd663 || d_gy[9:0] !== 10'd434) begin errors++; $display("FAIL reset_ghost0: got (%0d,%0d) expected (663,434)", d_gx[10:0], d_gy[9:0]); end
  endtask

  task automatic test_start();
    do_start();
    checks++; if (d_state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d expected 1", d_state); end
    checks++; if (d_lives !== 3'd3) begin errors++; $display("FAIL start_lives: got %0d expected 3", d_lives); end
    checks++; if (d_px !== 11'd967 || d_py !== 10'd66) begin errors++; $display("FAIL start_pac: got (%0d,%0d) expected (967,66)", d_px, d_py); end
    checks++; if (d_gx[10:0] !== 11'd663 || d_gy[9:0] !== 10'd434) begin errors++; $display("FAIL start_ghost0: got (%0d,%0d) expected (663,434)", d_gx[10:0], d_gy[9:0]); end
  endtask

  task automatic test_move();
    pac_dir = 4'b0001;
    gh_dir  = 16'h1111;
    for (int k = 1; k <= 4; k++) begin
      pulse_tick();
      checks++; if (d_px !== 11'(967 + k)) begin errors++; $display("FAIL move_pac_x%0d: got %0d expected %0d", k, d_px, 967 + k); end
      checks++; if (d_gx[10:0] !== 11'(663 + k / 2)) begin errors++; $display("FAIL move_ghost0_x%0d: got %0d expected %0d", k, d_gx[10:0], 663 + k / 2); end
    end
    checks++; if (d_gx[21:11] !== 11'd617) begin errors++; $display("FAIL move_ghost1_x: got %0d expected 617", d_gx[21:11]); end
    checks++; if (d_gprev !== 16'h1111) begin errors++; $display("FAIL move_gprev: got %0h expected 1111", d_gprev); end
    pac_dir = 4'd0;
    gh_dir  = 16'd0;
    // start while playing must not respawn or reload lives
    do_start();
    checks++; if (d_px !== 11'd971 || d_state !== 2'd1 || d_lives !== 3'd3) begin
      errors++; $display("FAIL start_in_play: got x=%0d state=%0d lives=%0d expected 971/1/3", d_px, d_state, d_lives);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    do_start();
    gh_dir  = 16'h2481;
    pac_dir = 4'b1000;
    repeat (3) pulse_tick();
    checks++; if (c_px !== 11'd0 || c_py !== 10'd0) begin errors++; $display("FAIL clamp_left: got (%0d,%0d) expected (0,0)", c_px, c_py); end
    pac_dir = 4'b0010;
    repeat (3) pulse_tick();
    checks++; if (c_px !== 11'd0 || c_py !== 10'd0) begin errors++; $display("FAIL clamp_up: got (%0d,%0d) expected (0,0)", c_px, c_py); end
    checks++; if (d_px !== 11'd964 || d_py !== 10'd63) begin errors++; $display("FAIL free_move: got (%0d,%0d) expected (964,63)", d_px, d_py); end
    checks++; if (c_gx[10:0] !== 11'd666 || c_gx[21:11] !== 11'd612) begin errors++; $display("FAIL ghost_x_mix: got (%0d,%0d) expected (666,612)", c_gx[10:0], c_gx[21:11]); end
    checks++; if (c_gy[29:20] !== 10'd69 || c_gy[39:30] !== 10'd367) begin errors++; $display("FAIL ghost_y_mix: got (%0d,%0d) expected (69,367)", c_gy[29:20], c_gy[39:30]); end
    checks++; if (c_gprev !== 16'h2481) begin errors++; $display("FAIL gprev_mix: got %0h expected 2481", c_gprev); end
    gh_dir  = 16'h3333;
    pac_dir = 4'b0011;
    repeat (2) pulse_tick();
    checks++; if (c_gprev !== 16'h2481) begin errors++; $display("FAIL multihot_gprev: got %0h expected 2481", c_gprev); end
    checks++; if (c_gx[10:0] !== 11'd666 || c_gy[39:30] !== 10'd367) begin errors++; $display("FAIL multihot_ghost: got (%0d,%0d) expected (666,367)", c_gx[10:0], c_gy[39:30]); end
    checks++; if (d_px !== 11'd964 || d_py !== 10'd63) begin errors++; $display("FAIL multihot_pac: got (%0d,%0d) expected (964,63)", d_px, d_py); end
    gh_dir  = 16'd0;
    pac_dir = 4'd0;
  endtask

  task automatic test_collision();
    do_reset();
    do_start();
    pac_dir = 4'b0001;
    repeat (9) pulse_tick();
    checks++; if (h_px !== 11'd976 || h_state !== 2'd1 || h_dead !== 1'b0) begin
      errors++; $display("FAIL pre_hit: got x=%0d state=%0d dead=%0d expected 976/1/0", h_px, h_state, h_dead);
    end
    pulse_tick();
    checks++; if (h_state !== 2'd2) begin errors++; $display("FAIL hit_state: got %0d expected 2", h_state); end
    checks++; if (h_dead !== 1'b1) begin errors++; $display("FAIL hit_pulse: got %0d expected 1", h_dead); end
    checks++; if (h_lives !== 3'd2) begin errors++; $display("FAIL hit_lives: got %0d expected 2", h_lives); end
    checks++; if (h_px !== 11'd976) begin errors++; $display("FAIL hit_no_move: got %0d expected 976", h_px); end
    pac_dir = 4'd0;
    step();
    checks++; if (h_dead !== 1'b0) begin errors++; $display("FAIL hit_pulse_len: got %0d expected 0", h_dead); end
  endtask

  task automatic test_death();
    repeat (7) pulse_tick();
    checks++; if (h_state !== 2'd2) begin errors++; $display("FAIL dying_hold: got %0d expected 2", h_state); end
    pulse_tick();
    checks++; if (h_state !== 2'd1 || h_lives !== 3'd2) begin errors++; $display("FAIL respawn_state: got %0d/%0d expected 1/2", h_state, h_lives); end
    checks++; if (h_px !== 11'd967 || h_py !== 10'd66 || h_gx[10:0] !== 11'd991) begin
      errors++; $display("FAIL respawn_pos: got (%0d,%0d) g0=%0d expected (967,66) g0=991", h_px, h_py, h_gx[10:0]);
    end
    gh_dir = 16'h0001;
    pulse_tick();
    checks++; if (h_gx[10:0] !== 11'd991) begin errors++; $display("FAIL gdiv_restart1: got %0d expected 991", h_gx[10:0]); end
    pulse_tick();
    checks++; if (h_gx[10:0] !== 11'd992) begin errors++; $display("FAIL gdiv_restart2: got %0d expected 992", h_gx[10:0]); end
    gh_dir = 16'd0;
  endtask

  task automatic test_game_over();
    do_reset();
    do_start();
    for (int r = 2; r >= 0; r--) begin
      step();
      checks++; if (o_state !== 2'd2 || o_lives !== 3'(r) || o_dead !== 1'b1) begin
        errors++; $display("FAIL life_lost%0d: got state=%0d lives=%0d dead=%0d expected 2/%0d/1", r, o_state, o_lives, o_dead, r);
      end
      repeat (8) pulse_tick();
      checks++; if (o_state !== ((r == 0) ? 2'd3 : 2'd1)) begin
        errors++; $display("FAIL after_dying%0d: got %0d expected %0d", r, o_state, (r == 0) ? 3 : 1);
      end
    end
    step();
    checks++; if (o_state !== 2'd3 || o_lives !== 3'd0 || o_dead !== 1'b0) begin
      errors++; $display("FAIL game_over_hold: got state=%0d lives=%0d dead=%0d expected 3/0/0", o_state, o_lives, o_dead);
    end
    do_start();
    checks++; if (o_state !== 2'd1 || o_lives !== 3'd3) begin errors++; $display("FAIL restart: got %0d/%0d expected 1/3", o_state, o_lives); end
  endtask

  task automatic test_pause();
    do_reset();
    pause = 1'b1;
    do_start();
    checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL pause_start: got %0d expected 1", o_state); end
    pac_dir = 4'b0001;
    repeat (3) pulse_tick();
    checks++; if (o_px !== 11'd967 || o_state !== 2'd1 || o_dead !== 1'b0 || o_lives !== 3'd3) begin
      errors++; $display("FAIL paused: got x=%0d state=%0d dead=%0d lives=%0d expected 967/1/0/3", o_px, o_state, o_dead, o_lives);
    end
    pause   = 1'b0;
    pac_dir = 4'd0;
    step();
    checks++; if (o_state !== 2'd2 || o_dead !== 1'b1 || o_lives !== 3'd2) begin
      errors++; $display("FAIL unpause_hit: got state=%0d dead=%0d lives=%0d expected 2/1/2", o_state, o_dead, o_lives);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b0;
    #1;
    checks++; if (o_state !== 2'd0 || o_dead !== 1'b0 || o_lives !== 3'd0) begin
      errors++; $display("FAIL async_reset: got state=%0d dead=%0d lives=%0d expected 0/0/0", o_state, o_dead, o_lives);
    end
    checks++; if (o_px !== 11'd967 || o_gx[10:0] !== 11'd975 || o_gprev !== 16'h0) begin
      errors++; $display("FAIL async_reset_pos: got x=%0d g0=%0d gprev=%0h expected 967/975/0", o_px, o_gx[10:0], o_gprev);
    end
    step();
    rst = 1'b1;
    step();
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL post_reset_idle: got %0d expected 0", o_state); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_start();
    test_move();
    test_clamp();
    test_collision();
    test_death();
    test_game_over();
    test_pause();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
